// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // size is funct3[1:0]: 00 byte, 01 half, otherwise word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte/half selection with sign or zero extension of a bus read word.
// The one-hot lane decode is also used by the store byte-enable logic.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] m_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic [3:0]  lane_oh
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select and extension by access width/sign
    always_comb begin
        lane_oh  = 4'b0001 << addr_lo;
        sel_byte = m_rdata[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   data = {24'h000000, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   data = {16'h0000, sel_half};
            default: data = m_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: req/ack bus master with store lane
// steering, load formatting, PC stall and bus timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] dmemout,
    output logic        done,
    output logic        misalign,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic        req;
    logic        mis;
    logic        fire;
    logic [1:0]  off_sel;
    logic [2:0]  f3_sel;
    logic [31:0] fmt_data;
    logic [3:0]  lane_oh;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // One aligner serves both paths: live address in IDLE for the store
    // lane decode, captured address in BUSY for load formatting.
    load_align u_align (
        .m_rdata (m_rdata),
        .addr_lo (off_sel),
        .funct3  (f3_sel),
        .data    (fmt_data),
        .lane_oh (lane_oh)
    );

    // Request decode, IDLE-phase stall/misalign and store lane steering
    always_comb begin
        req      = mem_rd | mem_wr;
        mis      = is_misaligned(funct3[1:0], addr[1:0]);
        fire     = (state == IDLE) && !rst && req && !mis;
        misalign = (state == IDLE) && !rst && req && mis;
        stall    = fire || (state == BUSY);
        off_sel  = (state == IDLE) ? addr[1:0] : off_q;
        f3_sel   = (state == IDLE) ? funct3 : funct3_q;
        case (funct3[1:0])
            2'b00: begin
                be_next    = lane_oh;
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = {{2{lane_oh[2]}}, {2{lane_oh[0]}}};
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Transaction FSM with registered bus, result and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            dmemout  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    dmemout <= '0;
                    if (fire) begin
                        state    <= BUSY;
                        tmo_cnt  <= '0;
                        off_q    <= addr[1:0];
                        funct3_q <= funct3;
                        m_req    <= 1'b1;
                        m_we     <= !mem_rd;
                        m_addr   <= {addr[31:2], 2'b00};
                        m_be     <= be_next;
                        m_wdata  <= wdata_next;
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        state   <= DONE;
                        m_req   <= 1'b0;
                        done    <= 1'b1;
                        dmemout <= m_we ? '0 : fmt_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= DONE;
                        m_req   <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        dmemout <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    dmemout <= '0;
                    m_we    <= 1'b0;
                    m_addr  <= '0;
                    m_wdata <= '0;
                    m_be    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute datapath and the data-memory bus of the RV32I core. It takes the ALU-computed address, store data and funct3 width/sign code, and runs a req/ack transaction on the memory bus. For stores it drives byte-lane shifts and byte enables. For loads it produces the byte-selected, sign/zero-extended `dmemout` that feeds the writeback mux, and it stalls the PC until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum BUSY cycles waiting for `m_ack` before aborting; range 1..255.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  synchronous active-high reset
- `mem_rd`  in  1  current instruction is a load
- `mem_wr`  in  1  current instruction is a store
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- `addr`  in  32  byte address (ALU output)
- `wdata`  in  32  store data (rs2)
- `stall`  out  1  hold PC and instruction
- `dmemout`  out  32  formatted load data, valid while `done`=1
- `done`  out  1  one-cycle completion pulse
- `misalign`  out  1  one-cycle pulse for a misaligned access
- `err`  out  1  one-cycle pulse on bus timeout
- `m_req`  out  1  bus request
- `m_we`  out  1  1 = write
- `m_addr`  out  32  word address; `{addr[31:2],2'b00}`
- `m_wdata`  out  32  store data shifted to its byte lane
- `m_be`  out  4  byte enables
- `m_ack`  in  1  bus acknowledge, one cycle
- `m_rdata`  in  32  read word, valid with `m_ack`

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - Request = `mem_rd|mem_wr`. If both are set, the load wins and the store is dropped.
  - Misaligned request: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. Pulse `misalign`, start no bus cycle, keep `stall`=0, drive `dmemout`=0, stay in IDLE.
  - Aligned request: register addr, funct3, we, shifted wdata and be; go to BUSY.
- BUSY
  - `m_req`=1; all `m_*` outputs hold stable until `m_ack`.
  - On `m_ack`: register the formatted load result and go to DONE.
  - If the timeout counter reaches `TIMEOUT_CYCLES` first: drop `m_req`, set the result to 0, flag `err`, go to DONE.
- DONE
  - `done`=1, `stall`=0, plus `err` if flagged. Always returns to IDLE.
  - Requests are ignored in this state, because the same instruction is still presented.
- Byte enables
  - B: `m_be = 4'b0001 << addr[1:0]`.
  - H: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
  - `m_wdata = wdata << (8*addr[1:0])`, with B/H replicated across lanes.
- Load formatting: select byte/half by `addr[1:0]`. B/H sign-extend from bit 7/15; BU/HU zero-extend. A store completion leaves `dmemout`=0.
- `stall` = (IDLE && aligned request) || BUSY. It is combinational in IDLE and registered-state driven thereafter.

## Timing
- Reset values: state IDLE; `m_req`, `m_we`, `m_be`, `m_addr`, `m_wdata`, `dmemout`, `done`, `misalign`, `err`, `stall` all 0; timeout counter 0.
- Latency
  - Request seen in IDLE at cycle 0; `m_req` high from cycle 1.
  - `m_ack` in cycle k≥1 gives `done` in cycle k+1. Minimum is 3 cycles per access, 2 of them stalled.
- Bus protocol
  - `m_ack` is sampled only in BUSY; `m_ack` in IDLE or DONE is ignored.
  - `m_req` deasserts the cycle after `m_ack`.
- Timeout counter
  - Clears on entry to BUSY and increments each BUSY cycle without ack.
  - If `m_ack` and timeout coincide, ack wins: data is captured and `err`=0.
- Reset mid-operation: at the next edge, FSM returns to IDLE and `m_req` drops. The transaction is abandoned with no `done`.

## Structure
- `lsu_pkg`: state enum (IDLE/BUSY/DONE) and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module `load_align`: combinational rdata byte-select plus sign/zero extension; inputs `m_rdata`, `addr[1:0]`, `funct3`. It is reused by the store-lane shifter for the offset decode.
- Top module holds the FSM, capture registers and timeout counter.

## Test plan
- LW at 0x100, `m_ack` on the 1st BUSY cycle with rdata 0xDEADBEEF → `m_be`=1111, `m_addr`=0x100; `done` in cycle 2 with `dmemout`=0xDEADBEEF; `stall` high in cycles 0–1.
- LB at 0x103, rdata 0x80FFFFFF → `dmemout`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202 with wdata 0x1234 → `m_we`=1, `m_be`=1100, `m_wdata[31:16]`=0x1234, `m_addr`=0x200.
- LW at 0x101 → `misalign` pulse in cycle 0, `m_req` never high, `stall`=0.
- `TIMEOUT_CYCLES`=4, no ack → `m_req` high for 4 cycles, then `done`=`err`=1 and `dmemout`=0.
- `rst` asserted during BUSY → next cycle IDLE with `m_req`=0 and no `done`; the following LW completes normally.
